wt_fetch_sched: RTL
===================

# wt_fetch_sched

Parametrised weight/bias fetch scheduler that sits between the single-port 576x72 parameter SRAM and the layer engines (conv1, conv2, conv3, fc). Each engine ("slot") requests its next parameter set; the block arbitrates round-robin, streams that set's words out of SRAM as a tagged burst, and advances a per-slot set index with wrap. Host write loads share the same SRAM port and always take priority. Per-slot word counts and base addresses are parameters, so new layers need no RTL change.

## Interface
- DW, 72: SRAM word width
- AW, 10: SRAM address width
- NSLOT, 4: number of consumer slots (≥2)
- SW, 2: slot-tag width, equal to clog2(NSLOT)
- SLOT_BASE, {10'd480,10'd352,10'd288,10'd0}: packed NSLOT×AW base addresses, slot 0 in the LSBs
- SLOT_WORDS, {8'd2,8'd4,8'd2,8'd9}: packed NSLOT×8 words per set, each 1..255
- SLOT_SETS, {8'd32,8'd32,8'd32,8'd32}: packed NSLOT×8 sets per slot, each 1..255
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  host write strobe
- wr_addr  in  AW  host write address
- wr_data  in  DW  host write data
- req  in  NSLOT  per-slot level request for the next set
- rewind  in  NSLOT  per-slot pulse that resets the set index to 0
- req_ack  out  NSLOT  one-hot pulse in the grant cycle
- out_valid  out  1  out_data is valid this cycle
- out_slot  out  SW  slot tag of out_data
- out_word  out  8  word index within the set
- out_last  out  1  final word of the set
- out_wrap  out  1  with out_last: this set was the slot's last (set index wraps)
- out_data  out  DW  SRAM read data
- busy  out  1  burst in progress
- mem_me, mem_we  out  1 each  SRAM enable and write enable
- mem_addr  out  AW  SRAM address
- mem_d  out  DW  SRAM write data
- mem_q  in  DW  SRAM read data, one cycle after the read is issued

## Operation
- States: IDLE and BURST. Per-slot registers: set_idx[s] (8 bits). Burst registers: cur_slot, word_cnt, rr_ptr.
- Write path: if wr_en=1, then mem_me=1, mem_we=1, mem_addr=wr_addr, mem_d=wr_data. No read is issued and no grant is given that cycle, in any state.
- IDLE, wr_en=0, and req≠0: grant the first requesting slot at or after rr_ptr in circular order. In that same cycle: req_ack[g]=1, issue read of word 0, go to BURST with word_cnt=1, and set rr_ptr=g+1 mod NSLOT.
- BURST, wr_en=0: issue read of word word_cnt, then increment word_cnt. If the word issued was word SLOT_WORDS-1, go to IDLE next cycle; this permits a back-to-back grant in the following cycle.
- BURST, wr_en=1: stall. word_cnt holds and no read is issued.
- Read address = SLOT_BASE[s] + set_idx[s]*SLOT_WORDS[s] + word, truncated to AW bits.
- Read data: each issued read produces exactly one output beat on the next cycle, with out_valid=1, out_data=mem_q, and tags registered at issue time. Output never stalls.
- Set advance: when the last word of a set is issued, set_idx[cur_slot] increments, or goes to 0 if it equals SLOT_SETS-1. out_wrap is 1 on that set's last beat when set_idx was SLOT_SETS-1.
- rewind[s]: set_idx[s] becomes 0 on the next edge. If this coincides with an advance of slot s, rewind wins and the value is 0. Rewind during a burst of slot s does not alter the addresses already in flight.
- A requester holds req until it sees req_ack. A req still high after the ack is treated as a new request.
- When out_valid=0: out_data, out_slot, out_word, out_last, and out_wrap are all 0.

## Timing
- Grant to first data: 1 cycle. An uninterrupted set of W words occupies cycles t..t+W-1 for issue and t+1..t+W for data.
- Each wr_en cycle during a burst adds exactly one cycle to the burst.
- Reset, including mid-burst: state=IDLE, every set_idx=0, rr_ptr=0. All outputs are 0 immediately. Any in-flight read is discarded, and out_valid=0 until a new grant is made.
- busy=1 from the cycle after grant up to the cycle after the last issue. mem_me is combinational from state and wr_en.

## Test plan
- Load sweep: write addr=k, data=k for k=0..575, then read back via slot 0 → 9 beats, data 0..8, out_last on word 8, set_idx[0]=1.
- Round-robin: req=4'b1111 held, re-raised after each ack → grants in order 0,1,2,3,0; slot 2's burst reads addresses 352..355; no idle gap between bursts.
- Write preemption: assert wr_en for 2 cycles during slot-1 word 1 → burst extends by 2 cycles, addresses 288/289 issued once each, out_valid gaps match the stall.
- Wrap: 32 requests on slot 3 → the 32nd set reads 542/543 with out_wrap=1; the 33rd reads 480.
- Rewind collision: pulse rewind[0] in the same cycle slot 0 issues its last word of set 5 → next slot-0 set starts at address 0.
- Mid-burst reset: assert rst at word 4 of slot 0 → all outputs 0 at once; after release, slot 0 restarts at address 0.

Source files
------------

// File: rtl/wt_fetch_sched.sv
// wt_fetch_sched
//   Round-robin weight/bias fetch scheduler in front of a single-port
//   parameter SRAM. Each consumer slot requests its next parameter set.
//   The winner's set is streamed out of SRAM as a tagged burst, one word
//   per cycle. Host writes share the SRAM port and always take priority:
//   a write blocks a grant, or stalls a running burst for one cycle.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   wr_en/addr/data     host write port (priority over reads)
//   req[NSLOT]          level request per slot, held until req_ack
//   rewind[NSLOT]       pulse: restart that slot at set 0
//   req_ack[NSLOT]      one-hot grant pulse
//   out_*               read beat, one cycle after issue, tagged
//   busy                burst in progress
//   mem_me/we/addr/d    SRAM control; mem_q is read data (1-cycle latency)
//
// state | meaning
// IDLE  | no burst; may grant a requesting slot
// BURST | streaming words 1..SLOT_WORDS-1 of the granted slot's set

module wt_fetch_sched #(
    parameter int DW    = 72,
    parameter int AW    = 10,
    parameter int NSLOT = 4,
    parameter int SW    = 2,
    parameter logic [NSLOT*AW-1:0] SLOT_BASE  = {10'd480, 10'd352, 10'd288, 10'd0},
    parameter logic [NSLOT*8-1:0]  SLOT_WORDS = {8'd2, 8'd4, 8'd2, 8'd9},
    parameter logic [NSLOT*8-1:0]  SLOT_SETS  = {8'd32, 8'd32, 8'd32, 8'd32}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DW-1:0]    wr_data,
    input  logic [NSLOT-1:0] req,
    input  logic [NSLOT-1:0] rewind,
    output logic [NSLOT-1:0] req_ack,
    output logic             out_valid,
    output logic [SW-1:0]    out_slot,
    output logic [7:0]       out_word,
    output logic             out_last,
    output logic             out_wrap,
    output logic [DW-1:0]    out_data,
    output logic             busy,
    output logic             mem_me,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_d,
    input  logic [DW-1:0]    mem_q
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;
    localparam int         AFW      = AW + 17;

    logic [0:0]    state, state_nxt;
    logic [SW-1:0] cur_slot;
    logic [7:0]    cur_set;
    logic [7:0]    word_cnt;
    logic [SW-1:0] rr_ptr;
    logic [AW-1:0] burst_base;
    logic [7:0]    set_idx [NSLOT];

    logic          out_valid_q;

    logic          grant_found;
    logic [SW-1:0] grant_slot;
    int            rr_cand;
    logic          grant;
    logic          burst_rd;
    logic          issue;
    logic [SW-1:0] sel_slot;
    logic [7:0]    sel_word;
    logic [7:0]    sel_words;
    logic [7:0]    sel_sets;
    logic [7:0]    sel_set;
    logic [AFW-1:0] grant_addr_full;
    logic [AW-1:0] rd_addr;
    logic          issue_last;
    logic          issue_wrap;

    // First requester at or after rr_ptr in circular order.
    always_comb begin
        grant_found = 1'b0;
        grant_slot  = '0;
        rr_cand     = 0;
        for (int i = 0; i < NSLOT; i++) begin
            rr_cand = (int'(rr_ptr) + i) % NSLOT;
            if (!grant_found && req[rr_cand]) begin
                grant_found = 1'b1;
                grant_slot  = SW'(rr_cand);
            end
        end
    end

    always_comb begin
        grant    = (state == ST_IDLE) && !wr_en && grant_found;
        burst_rd = (state == ST_BURST) && !wr_en;
        issue    = grant || burst_rd;

        sel_slot  = grant ? grant_slot : cur_slot;
        sel_word  = grant ? 8'd0 : word_cnt;
        sel_set   = grant ? set_idx[grant_slot] : cur_set;
        sel_words = SLOT_WORDS[int'(sel_slot)*8 +: 8];
        sel_sets  = SLOT_SETS[int'(sel_slot)*8 +: 8];

        grant_addr_full = AFW'(SLOT_BASE[int'(grant_slot)*AW +: AW])
                        + AFW'(set_idx[grant_slot]) * AFW'(SLOT_WORDS[int'(grant_slot)*8 +: 8]);

        // Later words of a burst use the base captured at grant so a rewind
        // mid-burst cannot redirect words of the set already being fetched.
        rd_addr = grant ? AW'(grant_addr_full) : AW'(burst_base + AW'(word_cnt));

        issue_last = issue && (sel_word == sel_words - 8'd1);
        issue_wrap = issue_last && (sel_set == sel_sets - 8'd1);

        state_nxt = state;
        if (grant && !issue_last) begin
            state_nxt = ST_BURST;
        end else if (burst_rd && issue_last) begin
            state_nxt = ST_IDLE;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    always_comb begin
        mem_me   = !rst && (wr_en || issue);
        mem_we   = !rst && wr_en;
        mem_addr = '0;
        if (!rst) begin
            if (wr_en) begin
                mem_addr = wr_addr;
            end else if (issue) begin
                mem_addr = rd_addr;
            end
        end
        mem_d    = (!rst && wr_en) ? wr_data : '0;
        req_ack  = (!rst && grant) ? (NSLOT'(1) << grant_slot) : '0;
        out_data = out_valid_q ? mem_q : '0;
    end

    assign out_valid = out_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cur_slot    <= '0;
            cur_set     <= '0;
            word_cnt    <= '0;
            rr_ptr      <= '0;
            burst_base  <= '0;
            busy        <= 1'b0;
            out_valid_q <= 1'b0;
            out_slot    <= '0;
            out_word    <= '0;
            out_last    <= 1'b0;
            out_wrap    <= 1'b0;
            for (int s = 0; s < NSLOT; s++) begin
                set_idx[s] <= '0;
            end
        end else begin
            state       <= state_nxt;
            busy        <= (state_nxt == ST_BURST) || issue_last;
            out_valid_q <= issue;
            out_slot    <= issue ? sel_slot : '0;
            out_word    <= issue ? sel_word : '0;
            out_last    <= issue_last;
            out_wrap    <= issue_wrap;

            if (grant) begin
                cur_slot   <= grant_slot;
                cur_set    <= set_idx[grant_slot];
                burst_base <= rd_addr;
                word_cnt   <= 8'd1;
                rr_ptr     <= (int'(grant_slot) == NSLOT - 1) ? '0 : grant_slot + 1'b1;
            end else if (burst_rd) begin
                word_cnt <= word_cnt + 8'd1;
            end

            // Rewind beats a coincident advance of the same slot.
            for (int s = 0; s < NSLOT; s++) begin
                if (rewind[s]) begin
                    set_idx[s] <= '0;
                end else if (issue_last && (sel_slot == SW'(s))) begin
                    set_idx[s] <= (set_idx[s] == SLOT_SETS[s*8 +: 8] - 8'd1) ? 8'd0
                                                                             : set_idx[s] + 8'd1;
                end
            end
        end
    end

endmodule
